// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART write-channel arbiter.
// Holds the FSM state encoding, the default end-of-line byte and the index-width helper.
package uart_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam logic [7:0] EOL_DEFAULT = 8'h0A;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART write-channel bundle for uart_tx_arbiter.
// master: requesters plus UART side (testbench/top level); slave: the arbiter.
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
  #(parameter int NREQ = 2) ();

  localparam int OW = idx_width(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              uart_wr_valid;
  logic [7:0]        uart_wr_data;
  logic              uart_wr_ready;
  logic [OW-1:0]     grant_id;
  logic              busy;

  modport master (
    output req_valid, req_data, uart_wr_ready,
    input  req_ready, uart_wr_valid, uart_wr_data, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, uart_wr_ready,
    output req_ready, uart_wr_valid, uart_wr_data, grant_id, busy
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching from ptr+1 upward,
// wrapping modulo N. Generic so other arbiters can reuse it.
module rr_pick
  import uart_arb_pkg::*;
  #(
    parameter  int N = 2,
    localparam int W = idx_width(N)
  ) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
  );

  logic [W-1:0] cand;

  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= N; k++) begin
      cand = W'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Line-locked arbiter sharing one UART write channel between NREQ requesters.
// A grant is held until an EOL byte, the burst limit, or TIMEOUT silent cycles.
//
// state  | meaning
// IDLE   | no owner; round-robin pick from rr_ptr+1, lock next cycle
// LOCKED | owner register valid; owner's bytes are forwarded to the UART
module uart_tx_arbiter
  import uart_arb_pkg::*;
  #(
    parameter int         NREQ      = 2,
    parameter int         MAX_BURST = 80,
    parameter int         TIMEOUT   = 255,
    parameter logic [7:0] EOL       = EOL_DEFAULT
  ) (
    input logic             CLK,
    input logic             RST_N,
    uart_tx_arbiter_if.slave bus
  );

  localparam int OW = idx_width(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  arb_state_e    state, state_nxt;
  logic [OW-1:0] owner, owner_nxt;
  logic [OW-1:0] rr_ptr, rr_ptr_nxt;
  logic [BW-1:0] burst_cnt, burst_nxt, burst_inc;
  logic [IW-1:0] idle_cnt, idle_nxt, idle_inc;

  logic          busy;
  logic          own_valid;
  logic [7:0]    own_data;
  logic          xfer;
  logic          silent;
  logic          pick_any;
  logic [OW-1:0] pick_idx;

  rr_pick #(.N(NREQ)) u_pick (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign busy      = (state == LOCKED);
  assign own_valid = bus.req_valid[owner];
  assign xfer      = busy & own_valid & bus.uart_wr_ready;
  assign silent    = busy & ~own_valid;
  assign burst_inc = burst_cnt + BW'(1);
  assign idle_inc  = idle_cnt + IW'(1);

  always_comb begin
    own_data      = 8'h00;
    bus.req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == OW'(i)) begin
        own_data         = bus.req_data[8*i +: 8];
        bus.req_ready[i] = busy & bus.uart_wr_ready;
      end
    end
  end

  assign bus.uart_wr_valid = busy & own_valid;
  assign bus.uart_wr_data  = busy ? own_data : 8'h00;
  assign bus.grant_id      = owner;
  assign bus.busy          = busy;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= OW'(NREQ - 1);
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_nxt;
      idle_cnt  <= idle_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    burst_nxt  = burst_cnt;
    idle_nxt   = idle_cnt;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = LOCKED;
          owner_nxt = pick_idx;
        end
      end
      LOCKED: begin
        if (xfer) begin
          burst_nxt = burst_inc;
          idle_nxt  = '0;
        end else if (silent) begin
          idle_nxt = idle_inc;
        end
        // Any combination of release causes collapses into one release.
        if ((xfer && ((own_data == EOL) || (burst_inc == BW'(MAX_BURST)))) ||
            (silent && (idle_inc == IW'(TIMEOUT)))) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = owner;
          burst_nxt  = '0;
          idle_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NREQ=2, MAX_BURST=4, TIMEOUT=5): cycle vector table
// plus hand-written sequences for toggled backpressure and asynchronous reset.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(2)) bus ();

  uart_tx_arbiter #(
    .NREQ(2), .MAX_BURST(4), .TIMEOUT(5), .EOL(8'h0A)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit         rst;
    logic [1:0] v;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       rdy;
    int         reps;
    logic       busy;
    logic       gid;
    logic       wv;
    logic [7:0] wd;
    logic [1:0] rr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic [1:0] v, logic [7:0] d0, logic [7:0] d1, logic rdy,
                              int reps, logic busy, logic gid, logic wv, logic [7:0] wd,
                              logic [1:0] rr);
    vec_t t;
    t.rst = 1'b0; t.v = v; t.d0 = d0; t.d1 = d1; t.rdy = rdy; t.reps = reps;
    t.busy = busy; t.gid = gid; t.wv = wv; t.wd = wd; t.rr = rr;
    vecs.push_back(t);
  endfunction

  function automatic void add_rst();
    vec_t t;
    t = '{rst: 1'b1, v: '0, d0: '0, d1: '0, rdy: 1'b0, reps: 0,
          busy: 1'b0, gid: 1'b0, wv: 1'b0, wd: '0, rr: '0};
    vecs.push_back(t);
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Entered and left on a falling edge; outputs are checked with reset still low.
  task automatic reset_dut();
    rst_n = 1'b0;
    bus.req_valid = '1;
    bus.req_data = '1;
    bus.uart_wr_ready = 1'b1;
    #1;
    chk("rst.busy", 32'(bus.busy), 0);
    chk("rst.wv", 32'(bus.uart_wr_valid), 0);
    chk("rst.wd", 32'(bus.uart_wr_data), 0);
    chk("rst.rr", 32'(bus.req_ready), 0);
    chk("rst.gid", 32'(bus.grant_id), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = '0;
    bus.req_data = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.uart_wr_ready = 1'b0;

    // "hi\n" from req0 alone
    add_rst();
    add(2'b01, 8'h68, 8'h00, 1, 1, 0, 0, 0, 8'h00, 2'b00);
    add(2'b01, 8'h68, 8'h00, 1, 1, 1, 0, 1, 8'h68, 2'b01);
    add(2'b01, 8'h69, 8'h00, 1, 1, 1, 0, 1, 8'h69, 2'b01);
    add(2'b01, 8'h0A, 8'h00, 1, 1, 1, 0, 1, 8'h0A, 2'b01);
    add(2'b00, 8'h00, 8'h00, 1, 1, 0, 0, 0, 8'h00, 2'b00);
    // contention from reset: req0 first, one dead cycle, req1, then req0 again
    add_rst();
    add(2'b11, 8'h61, 8'h42, 1, 1, 0, 0, 0, 8'h00, 2'b00);
    add(2'b11, 8'h61, 8'h42, 1, 1, 1, 0, 1, 8'h61, 2'b01);
    add(2'b11, 8'h0A, 8'h42, 1, 1, 1, 0, 1, 8'h0A, 2'b01);
    add(2'b10, 8'h00, 8'h42, 1, 1, 0, 0, 0, 8'h00, 2'b00);
    add(2'b10, 8'h00, 8'h42, 1, 1, 1, 1, 1, 8'h42, 2'b10);
    add(2'b10, 8'h00, 8'h0A, 1, 1, 1, 1, 1, 8'h0A, 2'b10);
    add(2'b11, 8'h63, 8'h44, 1, 1, 0, 0, 0, 8'h00, 2'b00);
    add(2'b11, 8'h63, 8'h44, 1, 1, 1, 0, 1, 8'h63, 2'b01);
    // burst limit of 4 on req1, req0 waiting
    add_rst();
    add(2'b10, 8'h00, 8'h10, 1, 1, 0, 0, 0, 8'h00, 2'b00);
    add(2'b11, 8'h0A, 8'h10, 1, 1, 1, 1, 1, 8'h10, 2'b10);
    add(2'b11, 8'h0A, 8'h11, 1, 1, 1, 1, 1, 8'h11, 2'b10);
    add(2'b11, 8'h0A, 8'h12, 1, 1, 1, 1, 1, 8'h12, 2'b10);
    add(2'b11, 8'h0A, 8'h13, 1, 1, 1, 1, 1, 8'h13, 2'b10);
    add(2'b11, 8'h0A, 8'h14, 1, 1, 0, 0, 0, 8'h00, 2'b00);
    add(2'b11, 8'h0A, 8'h14, 1, 1, 1, 0, 1, 8'h0A, 2'b01);
    add(2'b10, 8'h00, 8'h14, 1, 1, 0, 0, 0, 8'h00, 2'b00);
    add(2'b10, 8'h00, 8'h14, 1, 1, 1, 1, 1, 8'h14, 2'b10);
    add(2'b10, 8'h00, 8'h15, 1, 1, 1, 1, 1, 8'h15, 2'b10);
    add(2'b10, 8'h00, 8'h16, 1, 1, 1, 1, 1, 8'h16, 2'b10);
    add(2'b10, 8'h00, 8'h17, 1, 1, 1, 1, 1, 8'h17, 2'b10);
    add(2'b10, 8'h00, 8'h18, 1, 1, 0, 0, 0, 8'h00, 2'b00);
    add(2'b10, 8'h00, 8'h18, 1, 1, 1, 1, 1, 8'h18, 2'b10);
    add(2'b10, 8'h00, 8'h19, 1, 1, 1, 1, 1, 8'h19, 2'b10);
    add(2'b00, 8'h00, 8'h00, 1, 1, 1, 1, 0, 8'h00, 2'b10);
    // timeout after 5 silent cycles; 20 cycles of backpressure do not release
    add_rst();
    add(2'b01, 8'h55, 8'h00, 1, 1, 0, 0, 0, 8'h00, 2'b00);
    add(2'b01, 8'h55, 8'h00, 1, 1, 1, 0, 1, 8'h55, 2'b01);
    add(2'b00, 8'h00, 8'h00, 1, 5, 1, 0, 0, 8'h00, 2'b01);
    add(2'b01, 8'h77, 8'h00, 0, 1, 0, 0, 0, 8'h00, 2'b00);
    add(2'b01, 8'h77, 8'h00, 0, 20, 1, 0, 1, 8'h77, 2'b00);
    add(2'b01, 8'h77, 8'h00, 1, 1, 1, 0, 1, 8'h77, 2'b01);
    add(2'b00, 8'h00, 8'h00, 1, 1, 1, 0, 0, 8'h00, 2'b01);

    @(negedge clk);
    for (int k = 0; k < vecs.size(); k++) begin
      if (vecs[k].rst) begin
        reset_dut();
      end else begin
        for (int r = 0; r < vecs[k].reps; r++) begin
          bus.req_valid = vecs[k].v;
          bus.req_data = {vecs[k].d1, vecs[k].d0};
          bus.uart_wr_ready = vecs[k].rdy;
          #1;
          chk($sformatf("v%0d.%0d busy", k, r), 32'(bus.busy), 32'(vecs[k].busy));
          chk($sformatf("v%0d.%0d wv", k, r), 32'(bus.uart_wr_valid), 32'(vecs[k].wv));
          chk($sformatf("v%0d.%0d wd", k, r), 32'(bus.uart_wr_data), 32'(vecs[k].wd));
          chk($sformatf("v%0d.%0d rdy", k, r), 32'(bus.req_ready), 32'(vecs[k].rr));
          if (vecs[k].busy)
            chk($sformatf("v%0d.%0d gid", k, r), 32'(bus.grant_id), 32'(vecs[k].gid));
          @(negedge clk);
        end
      end
    end

    // toggled UART ready; req0 line split by burst limit, req1 slots in between
    begin
      logic [7:0] q0[6];
      logic [7:0] q1[2];
      logic [7:0] exp_s[8];
      logic [7:0] got[$];
      int i0;
      int i1;
      bit bad;
      q0 = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h0A};
      q1 = '{8'h5A, 8'h0A};
      exp_s = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h5A, 8'h0A, 8'h45, 8'h0A};
      i0 = 0;
      i1 = 0;
      bad = 1'b0;
      reset_dut();
      for (int cyc = 0; cyc < 80 && (i0 < 6 || i1 < 2); cyc++) begin
        bus.req_valid = {i1 < 2, i0 < 6};
        bus.req_data = {(i1 < 2) ? q1[i1] : 8'h00, (i0 < 6) ? q0[i0] : 8'h00};
        bus.uart_wr_ready = (cyc % 2 == 0);
        #1;
        if ($countones(bus.req_ready) > 1) bad = 1'b1;
        if (bus.req_ready != 2'b00 && (!bus.busy || !bus.uart_wr_ready)) bad = 1'b1;
        if (bus.req_ready & ~(2'b01 << bus.grant_id)) bad = 1'b1;
        if (bus.uart_wr_valid && bus.uart_wr_ready) got.push_back(bus.uart_wr_data);
        if (bus.req_ready[0] && bus.req_valid[0]) i0++;
        if (bus.req_ready[1] && bus.req_valid[1]) i1++;
        @(negedge clk);
      end
      chk("tog.done", 32'((i0 == 6) && (i1 == 2)), 1);
      chk("tog.count", 32'(got.size()), 8);
      chk("tog.nonowner", 32'(bad), 0);
      for (int k = 0; k < 8; k++)
        chk($sformatf("tog.byte%0d", k), (k < got.size()) ? 32'(got[k]) : 32'hFFFF_FFFF,
            32'(exp_s[k]));
      bus.req_valid = '0;
    end

    // asynchronous reset while req1 holds the channel
    reset_dut();
    bus.req_valid = 2'b10;
    bus.req_data = {8'h33, 8'h00};
    bus.uart_wr_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("ar.busy_pre", 32'(bus.busy), 1);
    chk("ar.gid_pre", 32'(bus.grant_id), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.busy", 32'(bus.busy), 0);
    chk("ar.wv", 32'(bus.uart_wr_valid), 0);
    chk("ar.rr", 32'(bus.req_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_data = {8'h33, 8'h30};
    @(negedge clk);
    #1;
    chk("ar.busy_post", 32'(bus.busy), 1);
    chk("ar.gid_post", 32'(bus.grant_id), 0);
    chk("ar.wd_post", 32'(bus.uart_wr_data), 32'h30);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
